seq: RTL and testbench

- Serial bit-stream pattern detector that flags every occurrence of "110" or "1101" on a 1-bit input. The earliest bit in each pattern arrives first.
- Overlapping matches are allowed.
- Moore-style finite state machine with a registered output.
- Sits in the front end of a serial data path as a simple framing/marker detector.

---
 rtl/seq.sv | 51 +++++
 tb/tb_seq.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/seq.sv
// rtl/seq.sv - serial detector flagging every overlapping "110" or "1101" on din
module seq (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  // Each state is the longest pattern prefix that is also a suffix of the bits seen so far.
  // The two match states double as the pulse sources for dout.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_1    = 3'd1,
    S_11   = 3'd2,
    S_110  = 3'd3,
    S_1101 = 3'd4
  } state_e;

  state_e state_q, state_d;
  logic   dout_q,  dout_d;

  // Next-state table; dout_d decodes the state being entered so dout is a plain flop.
  always_comb begin
    state_d = S_IDLE;
    dout_d  = 1'b0;
    unique case (state_q)
      S_IDLE: state_d = din ? S_1    : S_IDLE;
      S_1:    state_d = din ? S_11   : S_IDLE;
      S_11:   state_d = din ? S_11   : S_110;
      S_110:  state_d = din ? S_1101 : S_IDLE;
      S_1101: state_d = din ? S_11   : S_IDLE;
      // Unused encodings drop back to idle with no output.
      default: state_d = S_IDLE;
    endcase
    dout_d = (state_d == S_110) || (state_d == S_1101);
  end

  // State and output registers; reset wins over any bit arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      dout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: tb/tb_seq.sv
// tb/tb_seq.sv - randomized scoreboard bench for the seq pattern detector
module tb_seq;

  logic clk;
  logic rst;
  logic din;
  logic dout;

  seq dut (
    .clk  (clk),
    .rst  (rst),
    .din  (din),
    .dout (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic  exp;
    int    cyc;
    string tag;
  } exp_t;

  exp_t   sb_q[$];
  logic   hist[$];
  int     checks = 0;
  int     errors = 0;
  int     cyc_n  = 0;
  bit     started = 1'b0;
  bit     done    = 1'b0;

  // Reference: dout after an edge is 1 iff the bits received since the last reset end in 110 or 1101.
  function automatic logic model_match();
    int n;
    n = hist.size();
    if (n >= 3 && hist[n-3] == 1'b1 && hist[n-2] == 1'b1 && hist[n-1] == 1'b0)
      return 1'b1;
    if (n >= 4 && hist[n-4] == 1'b1 && hist[n-3] == 1'b1 && hist[n-2] == 1'b0 && hist[n-1] == 1'b1)
      return 1'b1;
    return 1'b0;
  endfunction

  task automatic step(input logic r, input logic d, input string tag);
    exp_t e;
    @(negedge clk);
    rst = r;
    din = d;
    @(posedge clk);
    if (r)
      hist.delete();
    else
      hist.push_back(d);
    e.exp = r ? 1'b0 : model_match();
    e.cyc = cyc_n;
    e.tag = tag;
    cyc_n++;
    sb_q.push_back(e);
    started = 1'b1;
  endtask

  task automatic send(input logic bits[$], input string tag);
    foreach (bits[i]) step(1'b0, bits[i], tag);
  endtask

  // Monitor: one registered output per edge, compared against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        checks++;
        if (dout !== e.exp) begin
          errors++;
          $display("FAIL %s cycle %0d: dout=%b expected %b", e.tag, e.cyc, dout, e.exp);
        end
      end else if (started && !done) begin
        checks++;
        errors++;
        $display("FAIL scoreboard: no expectation queued at cycle %0d", cyc_n);
      end
    end
  end

  initial begin
    logic bits[$];
    rst = 1'b1;
    din = 1'b0;

    step(1'b1, 1'b1, "reset");
    step(1'b1, 1'b0, "reset");
    bits = '{1'b1, 1'b0};
    send(bits, "post_reset");

    step(1'b1, 1'b0, "reset");
    bits = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    send(bits, "mixed");

    step(1'b1, 1'b0, "reset");
    bits = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    send(bits, "long_runs");

    bits = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    send(bits, "near_miss");

    bits = '{1'b1, 1'b1};
    send(bits, "mid_reset_pre");
    step(1'b1, 1'b0, "mid_reset");
    bits = '{1'b0};
    send(bits, "mid_reset_post");

    bits = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    send(bits, "overlap");

    bits = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    send(bits, "resume_11");

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 40) == 0)
        step(1'b1, 1'($urandom_range(0, 1)), "rand_reset");
      else
        step(1'b0, ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0, "random");
    end

    @(negedge clk);
    done = 1'b1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

endmodule
